// File: rtl/seq_tile_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier, one 2x2 tile product per clock.
// Define SEQ_TILE_MULT_APPROX_TILE_EN for approximate tiles (all but tile 0,0).
module seq_tile_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("seq_tile_mult: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    i;
  logic [CW-1:0]    j;

  logic [1:0]    a_d;
  logic [1:0]    b_d;
  logic [3:0]    tile;
  logic [CW:0]   dsum;
  logic [PW-1:0] term;
  logic [PW-1:0] sum;
  logic          last;

  assign a_d  = a_reg[2*i +: 2];
  assign b_d  = b_reg[2*j +: 2];
  assign dsum = {1'b0, i} + {1'b0, j};
  assign term = PW'(tile) << {dsum, 1'b0};
  assign sum  = acc + term;
  assign last = (i == LAST) && (j == LAST);

  always_comb begin
    tile = 4'(a_d) * 4'(b_d);
`ifdef SEQ_TILE_MULT_APPROX_TILE_EN
    // 3*3 reports 7 except on the least significant tile
    if ((i != '0 || j != '0) && a_d == 2'd3 && b_d == 2'd3)
      tile = 4'd7;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      P     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        CALC: begin
          acc <= sum;
          if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last) P <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tile_mult.sv
// Scoreboard bench for seq_tile_mult: directed WIDTH=8 vectors and
// exhaustive WIDTH=4 back-to-back traffic with random out_ready.
module tb_seq_tile_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic        or8 = 1'b1;
  logic [15:0] p8;
  logic        busy8;

  logic       iv4 = 1'b0;
  logic       ir4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       ov4;
  logic       or4 = 1'b1;
  logic [7:0] p4;
  logic       busy4;
  logic       rnd4 = 1'b0;

  seq_tile_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8),
    .P(p8), .busy(busy8)
  );

  seq_tile_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(or4),
    .P(p4), .busy(busy4)
  );

`ifdef SEQ_TILE_MULT_APPROX_TILE_EN
  localparam longint E13X11  = 135;
  localparam longint E255SQ  = 50577;
`else
  localparam longint E13X11  = 143;
  localparam longint E255SQ  = 65025;
`endif

  int compared   = 0;
  int mismatched = 0;
  longint q8[$];
  longint q4[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ref_prod(input int a, input int b,
                                      input int n);
`ifdef SEQ_TILE_MULT_APPROX_TILE_EN
    longint s = 0;
    for (int ii = 0; ii < n; ii++)
      for (int jj = 0; jj < n; jj++) begin
        longint t;
        t = longint'(((a >> (2*ii)) & 3) * ((b >> (2*jj)) & 3));
        if ((ii != 0 || jj != 0) && t == 9) t = 7;
        s += t << (2*(ii+jj));
      end
    return s;
`else
    if (n < 0) return 0;
    return longint'(a) * longint'(b);
`endif
  endfunction

  always @(negedge clk) begin
    if (ov8 && or8) begin
      if (q8.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL out8_unexpected: got P=%0d, required no output", p8);
      end else begin
        chk("p8", 64'(p8), 64'(q8.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (ov4 && or4) begin
      if (q4.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL out4_unexpected: got P=%0d, required no output", p4);
      end else begin
        chk("p4", 64'(p4), 64'(q4.pop_front()));
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd4) or4 = 1'($urandom_range(0, 1));
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input longint e, output int lat);
    a8  = a;
    b8  = b;
    iv8 = 1'b1;
    q8.push_back(e);
    tick();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int w;

    #1;
    chk("rst_in_ready", 64'(ir8), 1);
    chk("rst_out_valid", 64'(ov8), 0);
    chk("rst_busy", 64'(busy8), 0);
    chk("rst_p", 64'(p8), 0);
    tick();
    rst = 1'b0;
    tick();

    op8(8'd13, 8'd11, E13X11, lat);
    chk("lat_13x11", lat, 16);
    chk("busy_done", 64'(busy8), 1);
    tick();
    chk("ov_one_cycle", 64'(ov8), 0);
    chk("in_ready_back", 64'(ir8), 1);

    op8(8'd255, 8'd255, E255SQ, lat);
    chk("lat_255sq", lat, 16);
    tick();

    a8  = 8'd0;
    b8  = 8'd200;
    iv8 = 1'b1;
    q8.push_back(0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      iv8 = (k < 16) ? 1'(k) : 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      chk("calc_in_ready", 64'(ir8), 0);
      tick();
    end
    chk("zero_ov", 64'(ov8), 1);
    tick();
    tick();
    chk("zero_no_accept", 64'(busy8), 0);

    or8 = 1'b0;
    op8(8'd5, 8'd6, 30, lat);
    chk("lat_bp", lat, 16);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(ov8), 1);
      chk("bp_p", 64'(p8), 30);
      tick();
    end
    or8 = 1'b1;
    tick();
    chk("bp_released", 64'(ov8), 0);
    chk("bp_in_ready", 64'(ir8), 1);

    a8  = 8'd3;
    b8  = 8'd4;
    iv8 = 1'b1;
    q8.push_back(12);
    q8.push_back(12);
    tick();
    cnt = 0;
    while (!ir8 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("accept_interval", cnt + 1, 18);
    tick();
    iv8 = 1'b0;
    cnt = 0;
    while (!ov8 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("lat_second", cnt, 16);
    tick();

    a8  = 8'd200;
    b8  = 8'd100;
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 64'(ov8), 0);
    chk("mid_rst_p", 64'(p8), 0);
    chk("mid_rst_in_ready", 64'(ir8), 1);
    chk("mid_rst_busy", 64'(busy8), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(ir8), 1);
    chk("post_rst_ov", 64'(ov8), 0);
    op8(8'd7, 8'd9, 63, lat);
    chk("lat_7x9", lat, 16);
    tick();

    rnd4 = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        a4  = 4'(a);
        b4  = 4'(b);
        iv4 = 1'b1;
        w   = 0;
        while (!ir4 && w < 200) begin
          tick();
          w++;
        end
        if (w >= 200) begin
          compared++;
          mismatched++;
          $display("FAIL accept4_timeout: got no in_ready, required accept");
        end
        q4.push_back(ref_prod(a, b, 2));
        tick();
      end
    iv4  = 1'b0;
    rnd4 = 1'b0;
    or4  = 1'b1;

    cnt = 0;
    while ((q8.size() != 0 || q4.size() != 0) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("queues_drained", 64'(q8.size() + q4.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_tile_mult.md
Name: seq_tile_mult

Overview:
- Sequential, parametrised successor to the combinational 2-bit-tile 4x4 multipliers.
- Computes a WIDTH x WIDTH unsigned product by accumulating 2x2 tile products, one tile per clock.
- A valid/ready handshake sits on both input and output.
- Used where a wide product is needed and area matters more than latency; the optional approximate-tile mode matches the error profile of the approximate sub-multipliers.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; any other value is an elaboration error.
- N (localparam), WIDTH/2, number of 2-bit digits per operand; N*N tiles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands A, B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product P valid.
- out_ready  input  1  consumer accepts P.
- P  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset values (immediately on rst, no clock needed):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - P=0, accumulator=0, digit counters i=j=0.
- Digits: a_d[k] = A_reg[2k+1:2k], b_d[k] = B_reg[2k+1:2k]; tile(i,j) = a_d[i]*b_d[j], 4 bits.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: register A and B, clear acc, set i=j=0, go to CALC.
- State CALC:
  - in_ready=0; in_valid, A and B are ignored; registered operands are used only.
  - Each edge: acc += tile(i,j) << 2*(i+j), all in 2*WIDTH bits; the final sum never overflows.
  - Counter order: j increments; on j=N-1, j wraps to 0 and i increments.
  - On the edge that accumulates tile (N-1,N-1): P <= final sum, go to DONE.
- State DONE:
  - out_valid=1; P held stable.
  - On an edge with out_ready=1: go to IDLE and drop out_valid. P keeps its value until the next DONE.
- Latency:
  - Operands accepted at edge 0; tiles accumulated at edges 1..N*N.
  - out_valid is high after edge N*N (16 for WIDTH=8).
- Throughput: minimum accept-to-accept interval is N*N+2 cycles. in_ready is never high in DONE, so there is no same-cycle hand-over.
- Back-pressure: out_ready low holds DONE indefinitely with P and out_valid stable.
- Reset mid-operation: the async reset discards the partial accumulation; no output pulse. After release the block is in IDLE.
- out_valid is never asserted without a preceding accepted input.
- WIDTH=2: one tile; out_valid after edge 1.

Optional Feature:
- Macro: SEQ_TILE_MULT_APPROX_TILE_EN.
- Defined:
  - Tile (0,0) stays exact.
  - Every other tile uses the approximate 2x2 product: identical to exact except 3*3 gives 7 (4'b0111) instead of 9.
  - Timing and handshake are unchanged.
- Undefined: all tiles are exact; P = A*B for every input.

Test Plan:
- WIDTH=8, A=13, B=11, out_ready=1:
  - P=143, out_valid high exactly 16 cycles after the accept edge, high for 1 cycle.
  - in_ready returns high 1 cycle later.
- WIDTH=8, A=255, B=255:
  - P=65025 with the macro undefined.
  - P=50577 with SEQ_TILE_MULT_APPROX_TILE_EN defined (9 + 7*7224).
- A=0, B=200:
  - P=0 after 16 cycles.
  - Change A/B and toggle in_valid during CALC: result still 0, no extra accept.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises: P and out_valid stable.
  - Then out_ready=1: exactly one transfer; next accept possible at N*N+2 interval.
- Mid-operation reset:
  - Assert rst after the 5th tile of A=200, B=100.
  - out_valid=0, P=0, in_ready=1 immediately and after release.
  - Following operation A=7, B=9 gives P=63.
- Exhaustive:
  - WIDTH=4: random back-to-back operations with random out_ready.
  - All 256 pairs match A*B, or the approximate reference model when the macro is defined.
